// File: rtl/lsh_pkg.sv
// Shared types, state encoding and default sizes for the LSH window hashing pipeline.
package lsh_pkg;
    localparam int unsigned DEFAULT_SKETCH_SIZE         = 16;
    localparam int unsigned DEFAULT_LOG2_NUM_OF_BUCKETS = 8;
    localparam int unsigned DEFAULT_WINDOW_SIZE         = 128;
    localparam int unsigned DEFAULT_WINDOW_STRIDE       = 64;
    localparam int unsigned BASE_W                      = 2;
    localparam int unsigned INDEX_W                     = 16;
    localparam int unsigned STAT_W                      = 32;

    typedef logic [BASE_W-1:0] base_t;
    typedef logic [DEFAULT_LOG2_NUM_OF_BUCKETS-1:0] bucket_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HASH = 2'd2
    } sched_state_t;

    // Saturating increment for statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction
endpackage

// File: rtl/window_shift_reg.sv
// Base window shift register: index 0 holds the oldest base, new bases enter at the top.
module window_shift_reg
    import lsh_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_WINDOW_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    shift,
    input  logic [BASE_W-1:0]       din,
    output logic [BASE_W*DEPTH-1:0] window
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window <= '0;
        end else if (clear) begin
            window <= '0;
        end else if (shift) begin
            window <= {din, window[BASE_W*DEPTH-1:BASE_W]};
        end
    end
endmodule

// File: rtl/window_hash_scheduler.sv
// Sequences the window hasher over a base stream and buffers each sketch for the consumer.
// Optional statistics counters are enabled with WINDOW_HASH_SCHED_STATS_EN.
module window_hash_scheduler
    import lsh_pkg::*;
#(
    parameter int unsigned SKETCH_SIZE         = DEFAULT_SKETCH_SIZE,
    parameter int unsigned LOG2_NUM_OF_BUCKETS = DEFAULT_LOG2_NUM_OF_BUCKETS,
    parameter int unsigned WINDOW_SIZE         = DEFAULT_WINDOW_SIZE,
    parameter int unsigned WINDOW_STRIDE       = DEFAULT_WINDOW_STRIDE
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       seq_start,
    input  logic                                       base_valid,
    input  logic [BASE_W-1:0]                          base,
    output logic                                       base_ready,
    output logic [BASE_W*WINDOW_SIZE-1:0]              window,
    output logic                                       ready_for_hashing,
    input  logic [LOG2_NUM_OF_BUCKETS*SKETCH_SIZE-1:0] hashedSketch,
    input  logic                                       hashing_is_done,
    output logic                                       sketch_valid,
    input  logic                                       sketch_ready,
    output logic [LOG2_NUM_OF_BUCKETS*SKETCH_SIZE-1:0] sketch_out,
    output logic [INDEX_W-1:0]                         window_index
`ifdef WINDOW_HASH_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]                          stat_sketches,
    output logic [STAT_W-1:0]                          stat_stall_cycles
`endif
);
    localparam int unsigned CNT_W = $clog2(WINDOW_SIZE + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(WINDOW_SIZE);
    localparam logic [CNT_W-1:0] STRIDE_CNT = CNT_W'(WINDOW_STRIDE);

    sched_state_t       state;
    logic [CNT_W-1:0]   fill_cnt;
    logic [CNT_W-1:0]   target;
    logic [CNT_W-1:0]   cnt_inc;
    logic [INDEX_W-1:0] next_idx;
    logic               restart_pend;
    logic               accept;
    logic               slot_free;
    logic               count_met;
    logic               hash_done;
    logic               win_clear;

    assign count_met  = (fill_cnt == target);
    assign cnt_inc    = fill_cnt + CNT_W'(1);
    assign slot_free  = !sketch_valid || sketch_ready;
    // A restart in the same cycle as an offered base wins, so the base is refused.
    assign base_ready = (state == ST_FILL) && !count_met && !seq_start;
    assign accept     = base_valid && base_ready;
    assign hash_done  = (state == ST_HASH) && hashing_is_done;
    assign win_clear  = (seq_start && (state != ST_HASH)) ||
                        (hash_done && (restart_pend || seq_start));

    window_shift_reg #(
        .DEPTH (WINDOW_SIZE)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .clear  (win_clear),
        .shift  (accept),
        .din    (base),
        .window (window)
    );

    // Sequencing FSM, fill counters and the output sketch slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            fill_cnt          <= '0;
            target            <= '0;
            next_idx          <= '0;
            restart_pend      <= 1'b0;
            ready_for_hashing <= 1'b0;
            sketch_valid      <= 1'b0;
            sketch_out        <= '0;
            window_index      <= '0;
        end else begin
            if (sketch_valid && sketch_ready) begin
                sketch_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (seq_start) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                        target   <= FULL_CNT;
                        next_idx <= '0;
                    end
                end
                ST_FILL: begin
                    if (seq_start) begin
                        fill_cnt <= '0;
                        target   <= FULL_CNT;
                        next_idx <= '0;
                    end else if (accept) begin
                        fill_cnt <= cnt_inc;
                        if ((cnt_inc == target) && slot_free) begin
                            state             <= ST_HASH;
                            ready_for_hashing <= 1'b1;
                        end
                    end else if (count_met && slot_free) begin
                        state             <= ST_HASH;
                        ready_for_hashing <= 1'b1;
                    end
                end
                ST_HASH: begin
                    if (seq_start) begin
                        restart_pend <= 1'b1;
                    end
                    if (hashing_is_done) begin
                        state             <= ST_FILL;
                        ready_for_hashing <= 1'b0;
                        sketch_out        <= hashedSketch;
                        sketch_valid      <= 1'b1;
                        window_index      <= next_idx;
                        fill_cnt          <= '0;
                        // A restart requested during hashing takes effect on return to FILL.
                        if (restart_pend || seq_start) begin
                            next_idx     <= '0;
                            target       <= FULL_CNT;
                            restart_pend <= 1'b0;
                        end else begin
                            next_idx <= next_idx + INDEX_W'(1);
                            target   <= STRIDE_CNT;
                        end
                    end
                end
                default: begin
                    state             <= ST_IDLE;
                    ready_for_hashing <= 1'b0;
                end
            endcase
        end
    end

`ifdef WINDOW_HASH_SCHED_STATS_EN
    // Saturating statistics, cleared at the start of every sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_sketches     <= '0;
            stat_stall_cycles <= '0;
        end else if (seq_start) begin
            stat_sketches     <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (sketch_valid && sketch_ready) begin
                stat_sketches <= sat_inc(stat_sketches);
            end
            if (base_valid && !base_ready) begin
                stat_stall_cycles <= sat_inc(stat_stall_cycles);
            end
        end
    end
`endif
endmodule

// File: tb/tb_window_hash_scheduler.sv
// Self-checking bench for window_hash_scheduler: directed scenarios plus randomized traffic
// checked against a stream-level model of windows, indices and the output slot.
module tb_window_hash_scheduler;
    import lsh_pkg::*;

    localparam int WSIZE  = 128;
    localparam int STRIDE = 64;
    localparam int SKS    = 16;
    localparam int LB     = 8;
    localparam int SW     = SKS * LB;

    typedef struct packed {
        logic [SW-1:0] sk;
        logic [15:0]   idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            seq_start = 1'b0;
    logic            base_valid = 1'b0;
    logic [1:0]      base = 2'd0;
    logic            base_ready;
    logic [2*WSIZE-1:0] window;
    logic            ready_for_hashing;
    logic [SW-1:0]   hashedSketch = '0;
    logic            hashing_is_done = 1'b0;
    logic            sketch_valid;
    logic            sketch_ready = 1'b0;
    logic [SW-1:0]   sketch_out;
    logic [15:0]     window_index;
`ifdef WINDOW_HASH_SCHED_STATS_EN
    logic [31:0]     stat_sketches;
    logic [31:0]     stat_stall_cycles;
`endif

    window_hash_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .seq_start         (seq_start),
        .base_valid        (base_valid),
        .base              (base),
        .base_ready        (base_ready),
        .window            (window),
        .ready_for_hashing (ready_for_hashing),
        .hashedSketch      (hashedSketch),
        .hashing_is_done   (hashing_is_done),
        .sketch_valid      (sketch_valid),
        .sketch_ready      (sketch_ready),
        .sketch_out        (sketch_out),
        .window_index      (window_index)
`ifdef WINDOW_HASH_SCHED_STATS_EN
        ,
        .stat_sketches     (stat_sketches),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: bases accepted since the current sequence began.
    base_t stream[$];
    exp_t  exp_q[$];
    int    win_k;
    bit    pend;
    bit    started;
    int    h_wait;
    int    h_lat;
    bit    fixed_hash;
    bit    spur_en;
    int    dir_val;
    int    st_sk;
    int    st_stall;
    logic [15:0]   last_idx;
    logic [SW-1:0] last_sk;

    function automatic logic [SW-1:0] fixed_sketch();
        logic [SW-1:0] v;
        for (int i = 0; i < SKS; i++) v[i*LB +: LB] = LB'(i + 5);
        return v;
    endfunction

    task automatic model_reset();
        stream.delete();
        exp_q.delete();
        win_k = 0; pend = 0; started = 0; h_wait = 0; h_lat = 4;
        fixed_hash = 1; spur_en = 0; dir_val = 0; st_sk = 0; st_stall = 0;
        last_idx = 16'hffff; last_sk = '0;
    endtask

    // One clock cycle: drive inputs, play the hasher, then compare against the model.
    task automatic run_cycle(input logic bv, input logic [1:0] b, input logic ss,
                             input logic sr, output logic acc);
        logic br, rfh0, sv0, fire, exp_br, exp_rfh, exp_sv;
        logic [SW-1:0] so0, hs_now;
        logic [15:0] wi0;
        logic [2*WSIZE-1:0] ew;
        exp_t e;
        int need;
        base_valid = bv; base = b; seq_start = ss; sketch_ready = sr;
        fire = 1'b0;
        if (ready_for_hashing === 1'b1 && h_wait >= h_lat) fire = 1'b1;
        else if (ready_for_hashing !== 1'b1 && spur_en && $urandom_range(0, 49) == 0) fire = 1'b1;
        hashing_is_done = fire;
        hashedSketch = fixed_hash ? fixed_sketch() : {$urandom, $urandom, $urandom, $urandom};
        #1;
        br = base_ready; rfh0 = ready_for_hashing; sv0 = sketch_valid;
        so0 = sketch_out; wi0 = window_index; hs_now = hashedSketch;
        need = win_k * STRIDE + WSIZE;
        exp_br = started && !rfh0 && !ss && (stream.size() < need);
        checks++;
        if (br !== exp_br) begin
            errors++;
            $display("FAIL base_ready: got %b expected %b (stream %0d need %0d)", br, exp_br, stream.size(), need);
        end
        acc = bv && br;
        @(posedge clk);
        #1;
        seq_start = 1'b0; hashing_is_done = 1'b0; base_valid = 1'b0;
        #1;
        if (!ss) begin
            if (sv0 && sr) st_sk++;
            if (bv && !br) st_stall++;
        end else begin
            st_sk = 0; st_stall = 0;
        end
        if (sv0 && sr) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sketch_handshake: got unexpected sketch idx %0d", wi0);
            end else begin
                e = exp_q.pop_front();
                last_idx = wi0; last_sk = so0;
                if (so0 !== e.sk || wi0 !== e.idx) begin
                    errors++;
                    $display("FAIL sketch_out: got idx %0d sk %h expected idx %0d sk %h", wi0, so0, e.idx, e.sk);
                end
            end
        end
        if (acc) stream.push_back(b);
        if (fire && rfh0) begin
            exp_q.push_back('{sk: hs_now, idx: 16'(win_k)});
            if (pend || ss) begin
                stream.delete(); win_k = 0; pend = 0;
            end else begin
                win_k++;
            end
            h_wait = 0;
            if (!fixed_hash) h_lat = $urandom_range(0, 5);
            checks++;
            if (base_ready !== 1'b1) begin
                errors++;
                $display("FAIL base_ready_after_done: got %b expected 1", base_ready);
            end
        end else if (ss) begin
            if (rfh0) pend = 1;
            else begin stream.delete(); win_k = 0; started = 1; end
        end
        if (rfh0 && !fire) h_wait++;
        need = win_k * STRIDE + WSIZE;
        exp_rfh = rfh0 ? !fire : (started && !ss && stream.size() == need && (!sv0 || sr));
        exp_sv  = (fire && rfh0) || (sv0 && !sr);
        checks++;
        if (ready_for_hashing !== exp_rfh) begin
            errors++;
            $display("FAIL ready_for_hashing: got %b expected %b (stream %0d need %0d)", ready_for_hashing, exp_rfh, stream.size(), need);
        end
        checks++;
        if (sketch_valid !== exp_sv) begin
            errors++;
            $display("FAIL sketch_valid: got %b expected %b", sketch_valid, exp_sv);
        end
        if (exp_rfh && !rfh0 && ready_for_hashing === 1'b1) begin
            for (int j = 0; j < WSIZE; j++) ew[2*j +: 2] = stream[win_k * STRIDE + j];
            checks++;
            if (window !== ew) begin
                errors++;
                $display("FAIL window_content: window %0d got %h expected %h", win_k, window, ew);
            end
        end
    endtask

    task automatic feed(input int n, input logic sr, input logic rnd);
        logic acc;
        int got = 0;
        int budget = 0;
        while (got < n && budget < 4 * n + 200) begin
            run_cycle(1'b1, rnd ? 2'($urandom_range(0, 3)) : 2'(dir_val % 4), 1'b0, sr, acc);
            if (acc) begin got++; dir_val++; end
            budget++;
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL feed_timeout: accepted %0d expected %0d", got, n);
        end
    endtask

    task automatic finish_hash(input logic sr);
        logic acc;
        int n = 0;
        while (ready_for_hashing === 1'b1 && n < 100) begin
            run_cycle(1'b0, 2'd0, 1'b0, sr, acc);
            n++;
        end
        checks++;
        if (ready_for_hashing !== 1'b0) begin
            errors++;
            $display("FAIL hash_timeout: ready_for_hashing got %b expected 0", ready_for_hashing);
        end
        run_cycle(1'b0, 2'd0, 1'b0, sr, acc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        seq_start = 0; base_valid = 0; hashing_is_done = 0; sketch_ready = 0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
    endtask

    task automatic start_seq(input logic sr);
        logic acc;
        run_cycle(1'b0, 2'd0, 1'b1, sr, acc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (ready_for_hashing !== 1'b0 || base_ready !== 1'b0 || sketch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rfh %b br %b sv %b expected 0 0 0", ready_for_hashing, base_ready, sketch_valid);
        end
        checks++;
        if (sketch_out !== '0 || window_index !== 16'd0) begin
            errors++;
            $display("FAIL reset_slot: sketch_out %h idx %0d expected 0", sketch_out, window_index);
        end
        checks++;
        if (window !== '0) begin
            errors++;
            $display("FAIL reset_window: got %h expected 0", window);
        end
`ifdef WINDOW_HASH_SCHED_STATS_EN
        checks++;
        if (stat_sketches !== 32'd0 || stat_stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d %0d expected 0 0", stat_sketches, stat_stall_cycles);
        end
`endif
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
    endtask

    task automatic test_first_window();
        do_reset();
        start_seq(1'b1);
        feed(WSIZE, 1'b1, 1'b0);
        checks++;
        if (ready_for_hashing !== 1'b1 || window[1:0] !== 2'd0 || window[2*WSIZE-1 -: 2] !== 2'd3) begin
            errors++;
            $display("FAIL first_window: rfh %b w0 %0d w127 %0d expected 1 0 3", ready_for_hashing, window[1:0], window[2*WSIZE-1 -: 2]);
        end
        finish_hash(1'b1);
        checks++;
        if (last_idx !== 16'd0 || last_sk !== fixed_sketch()) begin
            errors++;
            $display("FAIL first_sketch: idx %0d sk %h expected 0 %h", last_idx, last_sk, fixed_sketch());
        end
        feed(STRIDE, 1'b1, 1'b0);
        checks++;
        if (ready_for_hashing !== 1'b1 || window[1:0] !== 2'd0 || window[3:2] !== 2'd1) begin
            errors++;
            $display("FAIL second_window: rfh %b w0 %0d w1 %0d expected 1 0 1", ready_for_hashing, window[1:0], window[3:2]);
        end
        finish_hash(1'b1);
        checks++;
        if (last_idx !== 16'd1) begin
            errors++;
            $display("FAIL second_index: got %0d expected 1", last_idx);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        do_reset();
        start_seq(1'b0);
        feed(WSIZE, 1'b0, 1'b0);
        finish_hash(1'b0);
        feed(STRIDE, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b1, 2'd2, 1'b0, 1'b0, acc);
            checks++;
            if (acc !== 1'b0 || ready_for_hashing !== 1'b0 || base_ready !== 1'b0) begin
                errors++;
                $display("FAIL blocked_slot: acc %b rfh %b br %b expected 0 0 0", acc, ready_for_hashing, base_ready);
            end
        end
        run_cycle(1'b0, 2'd0, 1'b0, 1'b1, acc);
        checks++;
        if (ready_for_hashing !== 1'b1 || last_idx !== 16'd0) begin
            errors++;
            $display("FAIL release_slot: rfh %b idx %0d expected 1 0", ready_for_hashing, last_idx);
        end
        finish_hash(1'b1);
        checks++;
        if (last_idx !== 16'd1) begin
            errors++;
            $display("FAIL backpressure_index: got %0d expected 1", last_idx);
        end
    endtask

    task automatic test_restart_fill();
        logic acc;
        do_reset();
        start_seq(1'b1);
        feed(50, 1'b1, 1'b0);
        run_cycle(1'b1, 2'd3, 1'b1, 1'b1, acc);
        checks++;
        if (acc !== 1'b0) begin
            errors++;
            $display("FAIL restart_drops_base: accepted %b expected 0", acc);
        end
        feed(WSIZE - 1, 1'b1, 1'b0);
        checks++;
        if (ready_for_hashing !== 1'b0) begin
            errors++;
            $display("FAIL restart_fill_early: rfh %b expected 0", ready_for_hashing);
        end
        feed(1, 1'b1, 1'b0);
        checks++;
        if (ready_for_hashing !== 1'b1) begin
            errors++;
            $display("FAIL restart_fill_full: rfh %b expected 1", ready_for_hashing);
        end
        finish_hash(1'b1);
        checks++;
        if (last_idx !== 16'd0) begin
            errors++;
            $display("FAIL restart_fill_index: got %0d expected 0", last_idx);
        end
    endtask

    task automatic test_restart_hash();
        logic acc;
        do_reset();
        h_lat = 6;
        start_seq(1'b1);
        feed(WSIZE, 1'b1, 1'b0);
        finish_hash(1'b1);
        feed(STRIDE, 1'b1, 1'b0);
        run_cycle(1'b0, 2'd0, 1'b0, 1'b1, acc);
        run_cycle(1'b0, 2'd0, 1'b1, 1'b1, acc);
        checks++;
        if (ready_for_hashing !== 1'b1) begin
            errors++;
            $display("FAIL restart_in_hash_level: rfh %b expected 1", ready_for_hashing);
        end
        finish_hash(1'b1);
        checks++;
        if (last_idx !== 16'd1) begin
            errors++;
            $display("FAIL restart_hash_delivered: idx %0d expected 1", last_idx);
        end
        feed(WSIZE - 1, 1'b1, 1'b1);
        checks++;
        if (ready_for_hashing !== 1'b0) begin
            errors++;
            $display("FAIL restart_hash_early: rfh %b expected 0", ready_for_hashing);
        end
        feed(1, 1'b1, 1'b1);
        finish_hash(1'b1);
        checks++;
        if (last_idx !== 16'd0) begin
            errors++;
            $display("FAIL restart_hash_index: got %0d expected 0", last_idx);
        end
    endtask

    task automatic test_random();
        logic acc;
        do_reset();
        fixed_hash = 0;
        spur_en = 1;
        start_seq(1'b1);
        for (int c = 0; c < 4000; c++) begin
            run_cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 2) != 0), acc);
        end
        spur_en = 0;
        for (int c = 0; c < 40; c++) run_cycle(1'b0, 2'd0, 1'b0, 1'b1, acc);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: %0d sketches outstanding expected 0", exp_q.size());
        end
`ifdef WINDOW_HASH_SCHED_STATS_EN
        checks++;
        if (stat_sketches !== 32'(st_sk) || stat_stall_cycles !== 32'(st_stall)) begin
            errors++;
            $display("FAIL random_stats: got %0d %0d expected %0d %0d", stat_sketches, stat_stall_cycles, st_sk, st_stall);
        end
`endif
    endtask

    task automatic test_reset_in_hash();
        do_reset();
        start_seq(1'b1);
        feed(WSIZE, 1'b1, 1'b0);
        finish_hash(1'b1);
        feed(STRIDE, 1'b1, 1'b0);
        checks++;
        if (ready_for_hashing !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hash: rfh %b expected 1", ready_for_hashing);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ready_for_hashing !== 1'b0 || base_ready !== 1'b0 || sketch_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl: rfh %b br %b sv %b expected 0 0 0", ready_for_hashing, base_ready, sketch_valid);
        end
        checks++;
        if (sketch_out !== '0 || window_index !== 16'd0 || window !== '0) begin
            errors++;
            $display("FAIL async_reset_data: sk %h idx %0d win %h expected 0", sketch_out, window_index, window);
        end
`ifdef WINDOW_HASH_SCHED_STATS_EN
        checks++;
        if (stat_sketches !== 32'd0 || stat_stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_stats: got %0d %0d expected 0 0", stat_sketches, stat_stall_cycles);
        end
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_window();
        test_backpressure();
        test_restart_fill();
        test_restart_hash();
        test_random();
        test_reset_in_hash();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
